// File: rtl/multi_debouncer.sv
// N-channel input debouncer: per-channel synchroniser, stability counter,
// registered rise/fall/changed pulses and an optional long-hold pulse.
module multi_debouncer #(
    parameter int   CHANNELS    = 4,
    parameter int   LIMIT       = 250000,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0,
    parameter int   HOLD_LIMIT  = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in_0,
    output logic [CHANNELS-1:0] out_0,
    output logic [CHANNELS-1:0] rise_0,
    output logic [CHANNELS-1:0] fall_0,
    output logic [CHANNELS-1:0] hold_0,
    output logic                changed_0
);

    localparam int              CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LIMIT - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]       r_cnt  [CHANNELS];
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic                r_changed;

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_diff;
    logic [CHANNELS-1:0] w_accept;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A change is accepted on the LIMIT-th consecutive cycle of disagreement.
    always_comb begin
        w_diff   = '0;
        w_accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_diff[i]   = w_s[i] ^ r_out[i];
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= {CHANNELS{INIT}};
            end
        end else begin
            r_sync[0] <= in_0;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
            r_out     <= {CHANNELS{INIT}};
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            r_out     <= r_out ^ w_accept;
            r_rise    <= w_accept & w_s;
            r_fall    <= w_accept & ~w_s;
            r_changed <= |w_accept;
        end
    end

    assign out_0     = r_out;
    assign rise_0    = r_rise;
    assign fall_0    = r_fall;
    assign changed_0 = r_changed;

    generate
        if (HOLD_LIMIT > 0) begin : g_hold
            localparam int            HW       = $clog2(HOLD_LIMIT + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
            localparam logic [HW-1:0] HOLD_ONE = HW'(1);

            logic [HW-1:0]       r_hcnt [CHANNELS];
            logic [CHANNELS-1:0] r_hold;

            // Saturating at HOLD_MAX gives exactly one pulse per press.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_hcnt[i] <= '0;
                    end
                    r_hold <= '0;
                end else begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!r_out[i]) begin
                            r_hcnt[i] <= '0;
                        end else if (r_hcnt[i] != HOLD_MAX) begin
                            r_hcnt[i] <= r_hcnt[i] + HOLD_ONE;
                        end
                        r_hold[i] <= r_out[i] && (r_hcnt[i] == HOLD_MAX - HOLD_ONE);
                    end
                end
            end

            assign hold_0 = r_hold;
        end else begin : g_no_hold
            assign hold_0 = '0;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (4 channels, LIMIT=4, 2 sync stages,
// HOLD_LIMIT=6); inputs change and outputs are sampled on the falling edge.
module tb_multi_debouncer;

    logic       clock;
    logic       reset_n;
    logic [3:0] in_0;
    logic [3:0] out_0;
    logic [3:0] rise_0;
    logic [3:0] fall_0;
    logic [3:0] hold_0;
    logic       changed_0;

    int n_tests = 0;
    int n_fail  = 0;

    multi_debouncer #(
        .CHANNELS   (4),
        .LIMIT      (4),
        .SYNC_STAGES(2),
        .INIT       (1'b0),
        .HOLD_LIMIT (6)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_0     (in_0),
        .out_0    (out_0),
        .rise_0   (rise_0),
        .fall_0   (fall_0),
        .hold_0   (hold_0),
        .changed_0(changed_0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [3:0] acc;

    initial begin
        reset_n = 1'b0;
        in_0    = 4'b0000;
        step(3);
        check("rst_out", out_0, 4'b0000);
        check("rst_pulses", {rise_0, fall_0, hold_0, 3'b000, changed_0}, 16'h0000);
        reset_n = 1'b1;

        // idle inputs: nothing may move
        acc = 4'b0000;
        repeat (20) begin
            @(negedge clock);
            acc = acc | rise_0 | fall_0 | hold_0 | {3'b000, changed_0};
        end
        check("t1_out", out_0, 4'b0000);
        check("t1_pulses", acc, 4'b0000);

        // clean step on ch0, then hold behaviour
        in_0[0] = 1'b1;
        step(5);
        check("t2_out_early", out_0, 4'b0000);
        check("t2_rise_early", rise_0, 4'b0000);
        step(1);
        check("t2_out", out_0, 4'b0001);
        check("t2_rise", rise_0, 4'b0001);
        check("t2_fall", fall_0, 4'b0000);
        check("t2_changed", changed_0, 1'b1);
        step(1);
        check("t2_rise_gone", rise_0, 4'b0000);
        check("t2_changed_gone", changed_0, 1'b0);
        step(4);
        check("t5_hold_early", hold_0, 4'b0000);
        step(1);
        check("t5_hold", hold_0, 4'b0001);
        acc = 4'b0000;
        repeat (10) begin
            @(negedge clock);
            acc = acc | hold_0;
        end
        check("t5_hold_once", acc, 4'b0000);
        in_0[0] = 1'b0;
        step(6);
        check("t5_fall", fall_0, 4'b0001);
        check("t5_fall_out", out_0, 4'b0000);
        check("t5_fall_changed", changed_0, 1'b1);
        step(2);
        in_0[0] = 1'b1;
        step(6);
        check("t5_rerise", rise_0, 4'b0001);
        step(6);
        check("t5_rehold", hold_0, 4'b0001);
        in_0[0] = 1'b0;
        step(10);
        check("t5_released", out_0, 4'b0000);

        // short glitches on ch1 never get through
        in_0[1] = 1'b1; step(3);
        in_0[1] = 1'b0; step(1);
        in_0[1] = 1'b1; step(3);
        in_0[1] = 1'b0;
        acc = 4'b0000;
        repeat (10) begin
            @(negedge clock);
            acc = acc | rise_0 | out_0;
        end
        check("t3_glitch", acc, 4'b0000);

        // staggered channels 2 and 3
        in_0[2] = 1'b1; step(1);
        in_0[3] = 1'b1; step(5);
        check("t4_rise2", rise_0, 4'b0100);
        check("t4_chg2", changed_0, 1'b1);
        step(1);
        check("t4_rise3", rise_0, 4'b1000);
        check("t4_out_hi", out_0, 4'b1100);
        step(5);
        check("t4_hold2", hold_0, 4'b0100);
        step(1);
        check("t4_hold3", hold_0, 4'b1000);
        in_0[2] = 1'b0; step(1);
        in_0[3] = 1'b0; step(5);
        check("t4_fall2", fall_0, 4'b0100);
        check("t4_out_mid", out_0, 4'b1000);
        step(1);
        check("t4_fall3", fall_0, 4'b1000);
        check("t4_out_lo", out_0, 4'b0000);
        step(3);

        // reset in the middle of a count, with ch1 already debounced high
        in_0[1] = 1'b1;
        step(6);
        check("t6_ch1_hi", out_0, 4'b0010);
        step(10);
        in_0[0] = 1'b1;
        step(3);
        reset_n = 1'b0;
        #1;
        check("t6_rst_out", out_0, 4'b0000);
        check("t6_rst_pulses", {rise_0, fall_0, hold_0, 3'b000, changed_0}, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        acc = 4'b0000;
        repeat (5) begin
            @(negedge clock);
            acc = acc | rise_0 | fall_0 | out_0;
        end
        check("t6_quiet", acc, 4'b0000);
        step(1);
        check("t6_rise", rise_0, 4'b0011);
        check("t6_out", out_0, 4'b0011);
        step(6);
        check("t6_hold", hold_0, 4'b0011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
